mux2_sel_arbiter: RTL
=====================

# mux2_sel_arbiter

Two-requester round-robin arbiter that generates the select line for the `mux2a1` 2:1 multiplexer directly downstream. It decides which of two sources, A or B, owns the shared mux output. It bounds each ownership period with a time-slice counter and guarantees fairness when both sources request continuously. All outputs are registered, so the mux's `Sel` input sees a clean, glitch-free value on every clock.

## Interface
- `SLICE`, default 8: maximum consecutive cycles per grant before the owner must yield to a waiting requester. Legal range 2..256.
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req_a`, input, 1: source A requests the mux output; level-sensitive.
- `req_b`, input, 1: source B requests the mux output; level-sensitive.
- `done`, input, 1: single-cycle release pulse from the current owner; ignored in IDLE.
- `sel`, output, 1: mux select, 0 = A, 1 = B; wired to `mux2a1.Sel`.
- `gnt_a`, output, 1: A currently owns the output.
- `gnt_b`, output, 1: B currently owns the output.
- `slice_cnt`, output, clog2(SLICE): cycles elapsed in the current grant, for debug and verification.

## Operation
- States: IDLE, GRANT_A, GRANT_B. `gnt_a` = (state == GRANT_A); `gnt_b` = (state == GRANT_B). The two grants are never high together.
- Priority pointer `prio`: 0 means A wins a tie, 1 means B wins. On entering GRANT_A, `prio` becomes 1. On entering GRANT_B, `prio` becomes 0.
- IDLE:
  - only `req_a` high → GRANT_A.
  - only `req_b` high → GRANT_B.
  - both high → the side indicated by `prio`.
  - neither high → stay in IDLE.
- GRANT_X, the owner's grant ends on any of:
  - the owner's `req` is low;
  - `done` is high;
  - `slice_cnt == SLICE-1` (expiry).
- On grant end:
  - the other side's `req` is high → go directly to GRANT_other; no idle cycle in between.
  - otherwise, if the owner's `req` is still high and the end was caused by expiry only → stay in GRANT_X and reload `slice_cnt` to 0.
  - otherwise → IDLE.
- `done` takes precedence over the owner's still-high `req`: after `done`, the owner re-arbitrates from IDLE on the next cycle.
- `slice_cnt`:
  - set to 0 on any state entry and on a renewed grant;
  - increments by 1 each cycle the grant is held;
  - never wraps past SLICE-1;
  - held at 0 in IDLE.
- `sel`:
  - loads 0 on entering GRANT_A and 1 on entering GRANT_B;
  - holds its last value in IDLE, so the mux does not toggle needlessly.

## Timing
- Reset values: state = IDLE, `prio` = 0, `sel` = 0, `gnt_a` = 0, `gnt_b` = 0, `slice_cnt` = 0.
- `rst_n` low at an edge forces the reset values at that edge, overriding any grant in progress. The first grant can occur at the first edge with `rst_n` high.
- Grant latency: a request sampled at edge N produces grant and `sel` valid after edge N, i.e. 1 cycle.
- Release latency: `done` or a dropped `req` at edge N clears the grant after edge N.
- `sel` and the grant lines change on the same edge. Downstream `Y` is valid one mux propagation delay after that edge.
- Maximum wait for a continuously requesting side while the other side also requests continuously: SLICE cycles.
- A `done` coinciding with expiry is handled as `done`.
- Simultaneous first requests after reset: A wins, because `prio` = 0.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `req_a`=`req_b`=1 → `gnt_a`=`gnt_b`=0, `sel`=0, `slice_cnt`=0 throughout.
- Single requester: `req_a`=1 from cycle 5 to cycle 10, `req_b`=0 → `gnt_a`=1 and `sel`=0 for 6 cycles starting 1 cycle later; returns to IDLE the cycle after `req_a` falls.
- Contention, SLICE=8: `req_a`=`req_b`=1 continuously from reset release → GRANT_A for 8 cycles, then GRANT_B for 8, alternating; `sel` toggles every 8 cycles; no idle gap between grants.
- Expiry renewal, SLICE=4: only `req_b`=1 for 12 cycles → `gnt_b` stays high; `slice_cnt` runs 0,1,2,3,0,1,2,3,…; `sel`=1 held.
- Done release: A owns the output, `done` pulsed when `slice_cnt`=2 while `req_b`=1 → GRANT_B on the next edge with `slice_cnt`=0; `prio`=0 afterwards.
- Reset mid-grant: `rst_n`=0 during GRANT_B at `slice_cnt`=5 → next edge gives IDLE, `sel`=0, `slice_cnt`=0; with both requests high after release, A is granted first.

Source files
------------

// File: rtl/mux2_sel_arbiter_if.sv
// Request/grant bundle between the two mux sources and the select arbiter.
// The requester side drives req_a/req_b/done and observes the grant outputs.
interface mux2_sel_arbiter_if #(
    parameter int SLICE = 8
);
    localparam int CNT_W = $clog2(SLICE);

    logic             req_a;
    logic             req_b;
    logic             done;
    logic             sel;
    logic             gnt_a;
    logic             gnt_b;
    logic [CNT_W-1:0] slice_cnt;

    modport master (
        output req_a, req_b, done,
        input  sel, gnt_a, gnt_b, slice_cnt
    );

    modport slave (
        input  req_a, req_b, done,
        output sel, gnt_a, gnt_b, slice_cnt
    );
endinterface

// File: rtl/mux2_sel_arbiter.sv
// Two-requester round-robin arbiter producing the select line of a 2:1 mux.
// Each grant is bounded by a time slice; all outputs come straight from flops.
module mux2_sel_arbiter #(
    parameter int SLICE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mux2_sel_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(SLICE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // State bits double as the grant lines, so gnt_a/gnt_b are plain flop outputs.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GNT_A = 2'b01;
    localparam logic [1:0] ST_GNT_B = 2'b10;

    logic [1:0]       state_q, state_d;
    logic             prio_q,  prio_d;
    logic             sel_q,   sel_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic grant_is_b;
    logic own_req;
    logic oth_req;
    logic expire;
    logic grant_end;

    // Next-state decision: arbitrate from IDLE, or decide hold/switch/renew/release while granted.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        grant_is_b = (state_q == ST_GNT_B);
        own_req    = grant_is_b ? bus.req_b : bus.req_a;
        oth_req    = grant_is_b ? bus.req_a : bus.req_b;
        expire     = (cnt_q == CNT_LAST);
        grant_end  = !own_req || bus.done || expire;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // A wins when alone, or on a tie while the pointer favours A.
                if (bus.req_a && (!bus.req_b || !prio_q)) begin
                    state_d = ST_GNT_A;
                    sel_d   = 1'b0;
                    prio_d  = 1'b1;
                end else if (bus.req_b) begin
                    state_d = ST_GNT_B;
                    sel_d   = 1'b1;
                    prio_d  = 1'b0;
                end
            end
            ST_GNT_A, ST_GNT_B: begin
                if (!grant_end) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (oth_req) begin
                    // Hand over directly, no idle cycle between owners.
                    cnt_d = '0;
                    if (grant_is_b) begin
                        state_d = ST_GNT_A;
                        sel_d   = 1'b0;
                        prio_d  = 1'b1;
                    end else begin
                        state_d = ST_GNT_B;
                        sel_d   = 1'b1;
                        prio_d  = 1'b0;
                    end
                end else if (own_req && !bus.done) begin
                    // Slice expired with nobody waiting: renew the same grant.
                    cnt_d = '0;
                end else begin
                    // Dropped request or done: go back and re-arbitrate; sel holds.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset overriding any grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt_a     = state_q[0];
    assign bus.gnt_b     = state_q[1];
    assign bus.slice_cnt = cnt_q;
endmodule
